// File: rtl/spi_mem_ctrl.sv
// CPU byte-bus to SPI serial SRAM bridge: each access becomes one CS-framed
// command / address-high / address-low / data exchange driven through spi_core.
module spi_mem_ctrl #(
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02,
    parameter int unsigned CS_GAP    = 2,
    parameter logic [7:0]  DUMMY_TX  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_data_wr,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [7:0]  bus_data_rd,
    output logic        bus_done,
    output logic        spi_cs_n,
    output logic [7:0]  spi_data_tx,
    output logic        spi_have_data,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_txn_done
);

    typedef enum logic [2:0] {
        IDLE, SETUP, CMD, ADDR_HI, ADDR_LO, DATA, FINISH, GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  tx_q, tx_d;
    logic        have_q, have_d;
    logic        done_q, done_d;
    logic [7:0]  rd_q, rd_d;
    logic [3:0]  gap_q, gap_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        cs_n_d    = cs_n_q;
        tx_d      = tx_q;
        have_d    = have_q;
        done_d    = 1'b0;
        rd_d      = rd_q;
        gap_d     = gap_q;

        unique case (state_q)
            IDLE: begin
                // Read has priority when the CPU raises both strobes.
                if (bus_read || bus_write) begin
                    addr_d    = bus_address;
                    wdata_d   = bus_data_wr;
                    is_read_d = bus_read;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cs_n_d  = 1'b0;
                tx_d    = is_read_q ? CMD_READ : CMD_WRITE;
                have_d  = 1'b1;
                state_d = CMD;
            end
            CMD: begin
                if (spi_txn_done) begin
                    tx_d    = addr_q[15:8];
                    state_d = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (spi_txn_done) begin
                    tx_d    = addr_q[7:0];
                    state_d = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (spi_txn_done) begin
                    tx_d    = is_read_q ? DUMMY_TX : wdata_q;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (spi_txn_done) begin
                    have_d = 1'b0;
                    if (is_read_q) begin
                        rd_d = spi_data_rx;
                    end
                    state_d = FINISH;
                end
            end
            FINISH: begin
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                gap_d   = 4'(CS_GAP);
                state_d = GAP;
            end
            GAP: begin
                // Chip select stays high for CS_GAP cycles before a new request is looked at.
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            is_read_q <= 1'b0;
            cs_n_q    <= 1'b1;
            tx_q      <= 8'h00;
            have_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 8'h00;
            gap_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            cs_n_q    <= cs_n_d;
            tx_q      <= tx_d;
            have_q    <= have_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            gap_q     <= gap_d;
        end
    end

    assign spi_cs_n      = cs_n_q;
    assign spi_data_tx   = tx_q;
    assign spi_have_data = have_q;
    assign bus_done      = done_q;
    assign bus_data_rd   = rd_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: a behavioural byte engine stands in for
// spi_core, and each access is checked against the expected 4-byte SRAM frame.
module tb_spi_mem_ctrl;

    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_wr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_rd;
    logic        bus_done;
    logic        spi_cs_n;
    logic [7:0]  spi_data_tx;
    logic        spi_have_data;
    logic [7:0]  spi_data_rx;
    logic        spi_txn_done;

    spi_mem_ctrl #(.CS_GAP(CS_GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_address   (bus_address),
        .bus_data_wr   (bus_data_wr),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_data_rd   (bus_data_rd),
        .bus_done      (bus_done),
        .spi_cs_n      (spi_cs_n),
        .spi_data_tx   (spi_data_tx),
        .spi_have_data (spi_have_data),
        .spi_data_rx   (spi_data_rx),
        .spi_txn_done  (spi_txn_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Engine / monitor state
    int         eng_t     = 8;
    int         eng_cnt   = 0;
    int         spur_req  = 0;
    int         stray     = 0;
    int         unstable  = 0;
    int         done_cnt  = 0;
    int         high_run  = 0;
    int         last_gap  = 0;
    logic [7:0] rx4       = 8'h00;
    logic [7:0] frame_q[$];

    // Reference model: last value a completed read returned.
    logic [7:0] exp_rd = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte engine: done arrives T cycles after a byte starts; MOSI byte captured at byte start.
    initial begin
        spi_txn_done = 1'b0;
        spi_data_rx  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_done) done_cnt++;
            if (spi_cs_n) begin
                high_run++;
            end else begin
                if (high_run > 0) last_gap = high_run;
                high_run = 0;
            end
            spi_txn_done = 1'b0;
            if (rst) begin
                eng_cnt = 0;
            end else if (spi_have_data) begin
                if (eng_cnt == 0) begin
                    frame_q.push_back(spi_data_tx);
                    if (spi_cs_n) stray++;
                end else if (frame_q.size() > 0 && spi_data_tx !== frame_q[frame_q.size()-1]) begin
                    unstable++;
                end
                eng_cnt++;
                if (eng_cnt >= eng_t) begin
                    spi_txn_done = 1'b1;
                    spi_data_rx  = (frame_q.size() == 4) ? rx4 : 8'($urandom);
                    eng_cnt      = 0;
                end
            end else begin
                eng_cnt = 0;
                if (spur_req > 0) begin
                    spi_txn_done = 1'b1;
                    spi_data_rx  = 8'($urandom);
                    spur_req--;
                end
            end
        end
    end

    // One CPU access; called and returns on a falling edge.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rx, input int t,
                             input bit chk_lat, input bit scramble);
        logic [7:0] exp_b[4];
        int cyc;
        int d0;
        bit seen;
        eng_t = t;
        rx4   = rx;
        frame_q.delete();
        d0 = done_cnt;
        exp_b[0] = rd ? 8'h03 : 8'h02;
        exp_b[1] = addr[15:8];
        exp_b[2] = addr[7:0];
        exp_b[3] = rd ? 8'h00 : wdata;
        bus_read    = rd;
        bus_write   = wr;
        bus_address = addr;
        bus_data_wr = wdata;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4*t + 40) begin
            @(negedge clk);
            cyc++;
            if (scramble && cyc == 4) begin
                bus_address = 16'($urandom);
                bus_data_wr = 8'($urandom);
                bus_read    = 1'b0;
                bus_write   = 1'b0;
            end
            if (bus_done) seen = 1'b1;
        end
        bus_read  = 1'b0;
        bus_write = 1'b0;
        check({tag, " done"}, 32'(seen), 32'd1);
        if (chk_lat) check({tag, " latency"}, cyc, 3 + 4*t);
        check({tag, " nbytes"}, frame_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s byte%0d", tag, i),
                  (frame_q.size() > i) ? 32'(frame_q[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
        end
        if (rd) exp_rd = rx;
        check({tag, " rdata"}, bus_data_rd, exp_rd);
        @(negedge clk);
        check({tag, " done_width"}, bus_done, 1'b0);
        check({tag, " done_count"}, done_cnt - d0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w;
        logic rd;
        logic wr;
        rst         = 1'b1;
        bus_address = 16'h0000;
        bus_data_wr = 8'h00;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        #23;
        check("reset cs_n", spi_cs_n, 1'b1);
        check("reset have", spi_have_data, 1'b0);
        check("reset tx", spi_data_tx, 8'h00);
        check("reset done", bus_done, 1'b0);
        check("reset rdata", bus_data_rd, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);

        do_access("read0102", 1'b1, 1'b0, 16'h0102, 8'hAA, 8'h3E, 8, 1'b1, 1'b0);
        idle_cycles(CS_GAP + 1);
        do_access("writeFF00", 1'b0, 1'b1, 16'hFF00, 8'h02, 8'h77, 8, 1'b1, 1'b0);
        idle_cycles(CS_GAP + 1);

        // Back-to-back: second request raised straight after the first completes.
        do_access("b2b_read", 1'b1, 1'b0, 16'h0000, 8'h00, 8'h5A, 4, 1'b1, 1'b0);
        do_access("b2b_write", 1'b0, 1'b1, 16'h0001, 8'hC3, 8'h11, 4, 1'b0, 1'b0);
        check("b2b cs_high_cycles", last_gap, CS_GAP + 2);
        idle_cycles(CS_GAP + 1);

        do_access("both", 1'b1, 1'b1, 16'hFFFF, 8'h99, 8'hE7, 3, 1'b1, 1'b0);

        // Spurious done pulses in GAP and IDLE must not move the FSM.
        spur_req = 4;
        d0 = done_cnt;
        idle_cycles(10);
        check("spur have", spi_have_data, 1'b0);
        check("spur cs_n", spi_cs_n, 1'b1);
        check("spur nbytes", frame_q.size(), 4);
        check("spur done", done_cnt - d0, 0);

        // Reset while the address-low byte is on the wire.
        eng_t = 8;
        frame_q.delete();
        d0 = done_cnt;
        bus_address = 16'h1234;
        bus_read    = 1'b1;
        w = 0;
        while (frame_q.size() < 3 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("abort reached addr_lo", frame_q.size(), 3);
        idle_cycles(2);
        #2 rst = 1'b1;
        #1;
        check("abort cs_n", spi_cs_n, 1'b1);
        check("abort have", spi_have_data, 1'b0);
        check("abort done", bus_done, 1'b0);
        bus_read = 1'b0;
        idle_cycles(2);
        rst = 1'b0;
        exp_rd = 8'h00;
        idle_cycles(8);
        check("abort no_done", done_cnt - d0, 0);
        check("abort nbytes", frame_q.size(), 3);
        check("abort rdata", bus_data_rd, 8'h00);

        do_access("read0005", 1'b1, 1'b0, 16'h0005, 8'h00, 8'h4C, 8, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            idle_cycles(CS_GAP + 1 + $urandom_range(0, 3));
            rd = 1'($urandom);
            wr = rd ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            do_access($sformatf("rand%0d", i), rd, wr, 16'($urandom), 8'($urandom),
                      8'($urandom), $urandom_range(1, 6), 1'b1, 1'($urandom));
        end

        check("stray bytes", stray, 0);
        check("tx unstable", unstable, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
